// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage control struct and default payload width.
package cpu_types_pkg;

    typedef struct packed {
        logic valid;
        logic flush;
    } pipe_ctrl_t;

    localparam int unsigned PIPE_DEFAULT_W = 32;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One elastic pipeline slot: valid+data register, plus a skid register when
// PIPE_STAGE_SKID_EN is defined. Empty entries always hold zero data.
module pipe_slot
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [DATA_W-1:0] down_data
);

    logic              v_q;
    logic [DATA_W-1:0] d_q;
    logic              accept;
    logic              adv;

    assign adv        = v_q && down_ready;
    assign accept     = up_valid && up_ready;
    assign down_valid = v_q;
    assign down_data  = d_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              sv_q;
    logic [DATA_W-1:0] sd_q;

    // Ready depends only on skid occupancy, so no combinational path from down_ready.
    assign up_ready = !sv_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_q  <= 1'b0;
            d_q  <= '0;
            sv_q <= 1'b0;
            sd_q <= '0;
        end else if (adv) begin
            if (sv_q) begin
                // Skid holds the older payload; it drains first. accept is 0 here.
                v_q  <= 1'b1;
                d_q  <= sd_q;
                sv_q <= 1'b0;
                sd_q <= '0;
            end else if (accept) begin
                v_q <= 1'b1;
                d_q <= up_data;
            end else begin
                v_q <= 1'b0;
                d_q <= '0;
            end
        end else if (accept) begin
            if (v_q) begin
                sv_q <= 1'b1;
                sd_q <= up_data;
            end else begin
                v_q <= 1'b1;
                d_q <= up_data;
            end
        end
    end
`else
    assign up_ready = !v_q || down_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else if (accept) begin
            v_q <= 1'b1;
            d_q <= up_data;
        end else if (adv) begin
            v_q <= 1'b0;
            d_q <= '0;
        end
    end
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register of DEPTH chained slots with flush.
// Optional skid registers (registered ready) via `define PIPE_STAGE_SKID_EN.
module pipe_stage_reg
    import cpu_types_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DEFAULT_W,
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned CNT_W  = $clog2(2*DEPTH+1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    // Index i is the link feeding slot i; index DEPTH is the output side.
    logic [DEPTH:0]    vld;
    logic [DEPTH:0]    rdy;
    logic [DATA_W-1:0] dat [DEPTH+1];

    assign vld[0]     = in_valid;
    assign dat[0]     = in_data;
    assign rdy[DEPTH] = out_ready;
    assign in_ready   = rdy[0];
    assign out_valid  = vld[DEPTH];
    assign out_data   = dat[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        pipe_slot #(
            .DATA_W(DATA_W)
        ) u_slot (
            .clk       (CLK),
            .rst       (RST),
            .flush     (flush),
            .up_valid  (vld[i]),
            .up_ready  (rdy[i]),
            .up_data   (dat[i]),
            .down_valid(vld[i+1]),
            .down_ready(rdy[i+1]),
            .down_data (dat[i+1])
        );
    end

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            occupancy <= '0;
        end else if (accept && !deliver) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!accept && deliver) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, elastic inter-stage pipeline register for the CPU pipeline; generalises the fixed-field stage latches into one reusable block.
- Carries an opaque DATA_W-bit payload (packed control + datapath fields) through DEPTH register slots.
- Uses a valid/ready handshake, so stalls from cache misses back-pressure cleanly.
- A synchronous flush turns every held entry into a bubble.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- DEPTH, 1, number of chained register slots (≥1); sets latency.
- CNT_W, $clog2(2*DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  synchronous bubble insert; clears all entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  block can accept the upstream payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head slot holds a valid payload.
- out_ready  in  1  downstream accepts the head payload this cycle.
- out_data  out  DATA_W  head payload; zero when out_valid=0.
- occupancy  out  CNT_W  number of valid entries held (main plus skid registers).

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset: every slot valid=0 and data=0.
  - Outputs after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Transfers:
  - Upstream transfer occurs when in_valid && in_ready at a rising edge.
  - Downstream transfer occurs when out_valid && out_ready at a rising edge.
- Slot chain: slot 0 takes input; slot DEPTH-1 drives the outputs.
  - Slot i loads from slot i-1 (or from the input, for i=0) when it is empty, or when its own contents advance in the same cycle.
  - adv[i] = v[i] && (i==DEPTH-1 ? out_ready : load[i+1]).
  - A slot that neither loads nor advances holds both valid and data.
- Latency: DEPTH cycles from accept to out_valid under no back-pressure. Throughput is 1 per cycle.
- in_ready (no skid): !v[0] || adv[0]. This is combinational from out_ready through the chain.
- Bubbles: when a slot advances and nothing loads into it, valid goes to 0 and data goes to 0. Invalid entries always carry zero data, so downstream control fields read as no-op.
- Flush:
  - Next edge: all valid=0 and all data=0.
  - An input presented in the flush cycle is dropped.
  - Any downstream handshake in the flush cycle still completes; the consumer samples it before the edge.
- Priority: RST > flush > normal operation.
- Occupancy: registered count of set valid bits; updated by +accept −deliver each cycle; forced to 0 on flush or RST.
  - With DEPTH=1 and no skid, it never exceeds 1.
- Simultaneous accept and deliver on a full slot: pass-through; occupancy unchanged.
- Back-pressure held indefinitely: data is stable and out_valid stays asserted; payload changes only after a transfer.
- RST or flush mid-stall: clears entries immediately; the next cycle has in_ready=1.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- With the macro defined:
  - Each slot gains one skid register.
  - in_ready (and each internal ready) becomes registered: in_ready = !skid_v[0]. This breaks the combinational ready path.
  - A payload accepted while the slot is stalled lands in the skid register. It drains to the main register before any newer input, preserving order.
  - Latency is unchanged. Maximum occupancy is 2*DEPTH.
  - Flush and RST also clear the skid registers.
- Without the macro: no skid registers; combinational ready as above; maximum occupancy is DEPTH.

Decomposition:
- Shared package cpu_types_pkg gets:
  - pipe_ctrl_t, a packed struct {logic valid; logic flush;} for the bench and the hazard unit.
  - localparam PIPE_DEFAULT_W = 32.
- One sub-module, pipe_slot: a single valid+data register with load/advance logic and the optional skid register, instantiated DEPTH times via generate.

Test Plan:
- RST=1 for 2 cycles, then 0 → out_valid=0, out_data=0, occupancy=0, in_ready=1.
- DEPTH=3: stream 0x11,0x22,0x33 with out_ready=1 → 0x11 appears exactly 3 cycles after accept; one output per cycle; occupancy peaks at 3.
- DEPTH=1: hold 0xAB with out_ready=0 for 5 cycles, in_valid=1 with 0xCD →
  - No skid: in_ready=0, out_data stays 0xAB.
  - PIPE_STAGE_SKID_EN: 0xCD is accepted into the skid, then in_ready=0; after release, outputs are 0xAB then 0xCD, with occupancy 2→1→0.
- DEPTH=2 holding 2 entries; assert flush with in_valid=1 and data 0x55 → next cycle occupancy=0, out_valid=0, out_data=0; 0x55 is never output.
- Flush and RST together with out_ready toggling → state matches reset and in_ready=1 the next cycle.
- Full pipeline with out_ready=1 and in_valid=1 continuously for 20 cycles → occupancy constant at DEPTH and no payload lost (scoreboard compare).
